dram_mp: RTL

- Parametrised multi-port DRAM behavioural model and successor to the fixed 8-port, 8-bit, shared-rdwr DRAM.
- Adds configurable port count, data and address width, depth and access latency.
- Adds per-port read/write select, a busy indication, and defined same-address conflict rules.
- Sits behind the parser/serialiser engines as their shared backing memory; all enabled ports are serviced as one batch per access.

---
 rtl/dram_mp.sv | 106 ++++++++++
 1 files changed

// File: rtl/dram_mp.sv
// rtl/dram_mp.sv - multi-port DRAM model: all enabled ports serviced as one batch after LATENCY cycles.
module dram_mp #(
    parameter int NUM_PORTS = 8,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 64,
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 20
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              en,
    input  logic [NUM_PORTS-1:0]              rdwr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  data_in,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]  data_out,
    output logic [NUM_PORTS-1:0]              valid,
    output logic                              busy
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                             state;
    state_t                             state_next;
    logic                               capture;
    logic                               commit;
    logic [CNT_W-1:0]                   cnt;
    logic [NUM_PORTS-1:0]               en_int;
    logic [NUM_PORTS-1:0]               rdwr_int;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   data_in_int;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]   addr_int;
    logic [DATA_W-1:0]                  mem [MEM_DEPTH];
    logic                               unused_addr_bits;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        commit     = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (|en) begin
                    capture    = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Upper address bits only select aliases of the same word.
    always_comb begin
        unused_addr_bits = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            unused_addr_bits = unused_addr_bits ^ (^addr_int[i][ADDR_W-1:IDX_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            valid       <= '0;
            data_out    <= '0;
            en_int      <= '0;
            rdwr_int    <= '0;
            data_in_int <= '0;
            addr_int    <= '0;
            for (int w = 0; w < MEM_DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            state <= state_next;
            valid <= commit ? en_int : '0;
            if (capture) begin
                en_int      <= en;
                rdwr_int    <= rdwr;
                data_in_int <= data_in;
                addr_int    <= addr;
                cnt         <= CNT_W'(LATENCY - 1);
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Reads see pre-batch contents; later ports overwrite earlier ones on a shared word.
            if (commit) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (en_int[i]) begin
                        if (rdwr_int[i]) begin
                            data_out[i] <= mem[addr_int[i][IDX_W-1:0]];
                        end else begin
                            mem[addr_int[i][IDX_W-1:0]] <= data_in_int[i];
                        end
                    end
                end
            end
        end
    end
endmodule
